// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and SPI mode constants.
package spi_pkg;

  // Transfer sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  // Mode is {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator and SCL phase tracker.
// The SCL level is kept as a phase bit (0 = at idle level) XORed with the
// latched CPOL, so a new CPOL shows on SCL the cycle it is latched.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic run,       // count half periods (any non-idle state)
  input  logic shift_en,  // SCL toggles only while shifting
  input  logic cpol,
  output logic tick,      // last cycle of a half period
  output logic lead,      // SCL leaves its idle level on this tick
  output logic trail,     // SCL returns to its idle level on this tick
  output logic scl
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          ph;

  assign tick  = run && (div_cnt == LAST);
  assign lead  = shift_en && tick && !ph;
  assign trail = shift_en && tick && ph;
  assign scl   = ph ^ cpol;

  // Half-period counter, restarts from zero whenever the master goes idle
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // SCL phase: toggles on every tick while shifting, parked at idle otherwise
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      ph <= 1'b0;
    end else if (!shift_en) begin
      ph <= 1'b0;
    end else if (tick) begin
      ph <= ~ph;
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// SPI master: variable-length (1..DATA_W bits) MSB-first transfers in all
// four SPI modes, with CLK_DIV clk_in cycles per SCL half period.
//
// Handshake: ready=1 means idle. A request is taken on a rising clk_in edge
// where ready=1; nbits/mode/mosi_data are captured on that same edge and the
// inputs are not looked at again until ready returns. Requests while ready=0
// are dropped. miso_data is valid from the cycle ready returns and holds
// until the next transfer finishes.
module spi_master_gen2
  import spi_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                      clk_in,
  input  logic                      nrst,
  input  logic [$clog2(DATA_W)-1:0] nbits,
  input  logic [1:0]                mode,
  input  logic [DATA_W-1:0]         mosi_data,
  input  logic                      request,
  output logic                      ready,
  output logic [DATA_W-1:0]         miso_data,
  output logic                      spi_cen,
  output logic                      spi_scl,
  output logic                      spi_sdi,
  input  logic                      spi_sdo,
  output logic [2:0]                dbg_state
);

  localparam int NB_W = $clog2(DATA_W);
  localparam int EW   = NB_W + 1;
  localparam logic [NB_W-1:0] TOP_BIT = NB_W'(DATA_W - 1);

  spi_state_e        state, state_nxt;
  logic [1:0]        mode_q;
  logic [NB_W-1:0]   nbits_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [EW-1:0]     edge_cnt;
  logic              tick, lead, trail;
  logic              accept, last_edge, cpha;
  logic              do_shift, do_sample;

  assign accept    = (state == IDLE) && request;
  assign cpha      = mode_q[0];
  // 2N-1 edges, N = nbits+1
  assign last_edge = (edge_cnt == {nbits_q, 1'b1});
  // CPHA=0: drive on trailing edges (none after the final one);
  // CPHA=1: drive on leading edges, the first one just exposes the MSB already in place
  assign do_shift  = cpha ? (lead && edge_cnt != '0) : (trail && !last_edge);
  assign do_sample = cpha ? trail : lead;

  assign ready     = (state == IDLE);
  assign spi_cen   = !(state == SETUP || state == SHIFT || state == HOLD);
  assign spi_sdi   = !spi_cen && tx_sr[DATA_W-1];
  assign dbg_state = state;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_in   (clk_in),
    .nrst     (nrst),
    .run      (state != IDLE),
    .shift_en (state == SHIFT),
    .cpol     (mode_q[1]),
    .tick     (tick),
    .lead     (lead),
    .trail    (trail),
    .scl      (spi_scl)
  );

  // State register
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: SETUP/HOLD/GAP last one half period, SHIFT lasts 2N half periods
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (request)             state_nxt = SETUP;
      SETUP:   if (tick)                state_nxt = SHIFT;
      SHIFT:   if (tick && last_edge)   state_nxt = HOLD;
      HOLD:    if (tick)                state_nxt = GAP;
      GAP:     if (tick)                state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Transfer parameters and shift registers; transmit word is left-justified
  // so the bit at nbits goes out first and anything above it is discarded
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      mode_q   <= MODE0;
      nbits_q  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
    end else if (accept) begin
      mode_q   <= mode;
      nbits_q  <= nbits;
      tx_sr    <= mosi_data << (TOP_BIT - nbits);
      rx_sr    <= '0;
      edge_cnt <= '0;
    end else begin
      if (state == SHIFT && tick) edge_cnt <= edge_cnt + EW'(1);
      if (do_shift)               tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
      if (do_sample)              rx_sr    <= {rx_sr[DATA_W-2:0], spi_sdo};
    end
  end

  // Received word is published only on the HOLD -> GAP transition
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      miso_data <= '0;
    end else if (state == HOLD && tick) begin
      miso_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Directed bench for spi_master_gen2 with a small LIS3DH-like slave model,
// loopback and constant MISO sources.
module tb_spi_master_gen2;

  localparam int DATA_W  = 32;
  localparam int CLK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic clk_go = 1'b0;
  logic nrst   = 1'b0;

  initial begin
    wait (clk_go);
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT ----------------
  logic [4:0]        nbits = '0;
  logic [1:0]        mode = '0;
  logic [DATA_W-1:0] mosi_data = '0;
  logic              request = 1'b0;
  logic              ready;
  logic [DATA_W-1:0] miso_data;
  logic              spi_cen, spi_scl, spi_sdi, spi_sdo;
  logic [2:0]        dbg_state;

  int   sdo_sel   = 0;     // 0: stub, 1: loopback, 2: constant
  logic sdo_const = 1'b0;
  logic stub_sdo  = 1'b0;

  assign spi_sdo = (sdo_sel == 0) ? stub_sdo : (sdo_sel == 1) ? spi_sdi : sdo_const;

  spi_master_gen2 #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk_in    (clk_in),
    .nrst      (nrst),
    .nbits     (nbits),
    .mode      (mode),
    .mosi_data (mosi_data),
    .request   (request),
    .ready     (ready),
    .miso_data (miso_data),
    .spi_cen   (spi_cen),
    .spi_scl   (spi_scl),
    .spi_sdi   (spi_sdi),
    .spi_sdo   (spi_sdo),
    .dbg_state (dbg_state)
  );

  // ---------------- lis3dh_stub: mode 0, answers 0x33 to read of 0x0F ----------------
  int         stub_rise = 0;
  int         stub_fall = 0;
  logic [7:0] stub_cmd  = '0;
  logic [7:0] stub_out  = '0;

  always @(negedge spi_cen) begin
    stub_rise = 0;
    stub_fall = 0;
    stub_sdo  = 1'b0;
  end

  always @(posedge spi_scl) begin
    if (!spi_cen) begin
      if (stub_rise < 8) stub_cmd = {stub_cmd[6:0], spi_sdi};
      stub_rise++;
    end
  end

  always @(negedge spi_scl) begin
    if (!spi_cen) begin
      stub_fall++;
      if (stub_fall == 8) stub_out = (stub_cmd == 8'h8F) ? 8'h33 : 8'h00;
      if (stub_fall >= 8 && stub_fall < 16) begin
        stub_sdo = stub_out[7];
        stub_out = {stub_out[6:0], 1'b0};
      end
    end
  end

  // ---------------- bus monitor: SCL edges inside CEN window, ready-low cycles ----------------
  int   edges    = 0;
  int   rdy_low  = 0;
  logic scl_prev = 1'b0;
  logic cen_prev = 1'b1;

  always @(negedge clk_in) begin
    if (!spi_cen && !cen_prev && spi_scl != scl_prev) edges++;
    if (!ready) rdy_low++;
    scl_prev = spi_scl;
    cen_prev = spi_cen;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [4:0] nb, input logic [1:0] md, input logic [DATA_W-1:0] data);
    @(posedge clk_in);
    #1;
    edges     = 0;
    rdy_low   = 0;
    nbits     = nb;
    mode      = md;
    mosi_data = data;
    request   = 1'b1;
    @(posedge clk_in);
    #1;
    request   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in);
      if (ready) break;
    end
    #1;
    check_eq({tag, "_done"}, ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset values with no clock running
    #2;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_cen", spi_cen, 1'b1);
    check_eq("rst_scl", spi_scl, 1'b0);
    check_eq("rst_sdi", spi_sdi, 1'b0);
    check_eq("rst_miso", miso_data, '0);

    clk_go = 1'b1;
    repeat (3) @(posedge clk_in);
    #2 nrst = 1'b1;

    // mode 0 WHO_AM_I read from stub: 16 pulses, (2*16+3)*4 = 140 busy cycles
    sdo_sel = 0;
    start_xfer(5'd15, 2'b00, 32'h0000_8f00);
    check_eq("m0_busy", ready, 1'b0);
    check_eq("m0_cen", spi_cen, 1'b0);
    wait_done("m0", 400);
    check_eq("m0_edges", edges, 32);
    check_eq("m0_rdy_low", rdy_low, 140);
    check_eq("m0_miso_lo", miso_data[7:0], 8'h33);
    check_eq("m0_miso", miso_data, 32'h0000_0033);
    check_eq("m0_cen_idle", spi_cen, 1'b1);
    check_eq("m0_sdi_idle", spi_sdi, 1'b0);

    // mode 3 loopback, 32 bits
    sdo_sel = 1;
    start_xfer(5'd31, 2'b11, 32'hA5C3_0F81);
    check_eq("m3_scl_before", spi_scl, 1'b1);
    wait_done("m3", 800);
    check_eq("m3_miso", miso_data, 32'hA5C3_0F81);
    check_eq("m3_edges", edges, 64);
    check_eq("m3_rdy_low", rdy_low, 268);
    check_eq("m3_scl_after", spi_scl, 1'b1);
    repeat (5) @(posedge clk_in);
    #1 check_eq("m3_miso_hold", miso_data, 32'hA5C3_0F81);

    // mode 0 loopback 8 bits with a request pulsed mid-transfer
    start_xfer(5'd7, 2'b00, 32'hFFFF_FF5A);
    check_eq("mid_scl_idle", spi_scl, 1'b0);
    repeat (20) @(posedge clk_in);
    #1;
    nbits     = 5'd15;
    mosi_data = 32'h0000_FFFF;
    request   = 1'b1;
    @(posedge clk_in);
    #1 request = 1'b0;
    wait_done("mid", 400);
    check_eq("mid_edges", edges, 16);
    check_eq("mid_rdy_low", rdy_low, 76);
    check_eq("mid_miso", miso_data, 32'h0000_005A);
    rdy_low = 0;
    repeat (30) @(posedge clk_in);
    #1 check_eq("mid_no_queue", rdy_low, 0);

    // reset after 5 pulses aborts the transfer
    start_xfer(5'd15, 2'b00, 32'h0000_1234);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (edges >= 10) break;
    end
    check_eq("abort_reach5", (edges >= 10), 1'b1);
    #2 nrst = 1'b0;
    #1;
    check_eq("abort_cen", spi_cen, 1'b1);
    check_eq("abort_ready", ready, 1'b1);
    check_eq("abort_scl", spi_scl, 1'b0);
    check_eq("abort_sdi", spi_sdi, 1'b0);
    check_eq("abort_miso", miso_data, '0);
    @(negedge clk_in);
    nrst = 1'b1;
    start_xfer(5'd7, 2'b00, 32'h0000_00C3);
    wait_done("post_rst", 400);
    check_eq("post_rst_miso", miso_data, 32'h0000_00C3);
    check_eq("post_rst_edges", edges, 16);

    // single-bit transfer, mode 1, constant MISO = 1; upper mosi bits ignored
    sdo_sel   = 2;
    sdo_const = 1'b1;
    start_xfer(5'd0, 2'b01, 32'hFFFF_FFF1);
    wait_done("one", 200);
    check_eq("one_edges", edges, 2);
    check_eq("one_miso", miso_data, 32'h0000_0001);
    check_eq("one_rdy_low", rdy_low, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
